// File: rtl/vliw_issue_sched_pkg.sv
// Shared definitions for the VLIW issue scheduler: slot field layout,
// register-file sizing and FSM state encodings.
package vliw_issue_sched_pkg;

    localparam int SLOT_W   = 32;
    localparam int NREG     = 32;
    localparam int SB_W     = 2 * NREG;
    localparam int REG_W    = 5;

    localparam int V_BIT    = 31;
    localparam int BANK_BIT = 30;
    localparam int OP_LSB   = 24;
    localparam int RD_LSB   = 19;
    localparam int RS1_LSB  = 14;
    localparam int RS2_LSB  = 9;
    localparam int IMM_LSB  = 0;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    // Scoreboard index is {bank, reg}: greg at 0..31, freg at 32..63.
    function automatic logic [5:0] rd_idx(input logic [SLOT_W-1:0] s);
        return {s[BANK_BIT], s[RD_LSB +: REG_W]};
    endfunction

    function automatic logic [5:0] rs1_idx(input logic [SLOT_W-1:0] s);
        return {s[BANK_BIT], s[RS1_LSB +: REG_W]};
    endfunction

    function automatic logic [5:0] rs2_idx(input logic [SLOT_W-1:0] s);
        return {s[BANK_BIT], s[RS2_LSB +: REG_W]};
    endfunction

endpackage

// File: rtl/vliw_issue_sched_scoreboard.sv
// Busy-register scoreboard: bits set at issue, cleared ALU_LAT cycles later
// by a shift pipe of write masks. A same-cycle set beats a retire clear.
module vliw_scoreboard
    import vliw_issue_sched_pkg::*;
#(
    parameter int ALU_LAT = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            set_en,
    input  logic [SB_W-1:0] set_mask,
    output logic [SB_W-1:0] sb_busy,
    output logic [SB_W-1:0] retire_mask
);

    logic [SB_W-1:0] pipe [ALU_LAT];
    logic [SB_W-1:0] set_bits;

    assign set_bits    = set_en ? set_mask : '0;
    assign retire_mask = pipe[ALU_LAT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ALU_LAT; i++) pipe[i] <= '0;
            sb_busy <= '0;
        end else begin
            pipe[0] <= set_bits;
            for (int i = 1; i < ALU_LAT; i++) pipe[i] <= pipe[i-1];
            sb_busy <= (sb_busy & ~retire_mask) | set_bits;
        end
    end

endmodule

// File: rtl/vliw_issue_sched.sv
// Issue scheduler: latches one bundle, drops intra-bundle duplicate writes,
// holds it until no RAW/WAW hazard remains, then issues all lanes at once.
//
//  state  | meaning
//  S_IDLE | ready for a bundle; latches it on bundle_valid
//  S_HOLD | bundle held; issues when hazard-free, otherwise stalls
module vliw_issue_sched
    import vliw_issue_sched_pkg::*;
#(
    parameter int NLANE   = 26,
    parameter int ALU_LAT = 3,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    bundle_valid,
    output logic                    bundle_ready,
    input  logic [1023:0]           bundle,
    input  logic                    flush,
    output logic                    issue_valid,
    output logic [NLANE-1:0]        issue_lane_en,
    output logic [SLOT_W*NLANE-1:0] issue_slots,
    output logic [SB_W-1:0]         sb_busy,
    output logic [CNT_W-1:0]        stall_cycles,
    output logic                    err_waw
);

    state_t                    state, state_next;
    logic [SLOT_W*NLANE-1:0]   slots_q, slots_in;
    logic [NLANE-1:0]          v_in, dup, lane_v;
    logic [SB_W-1:0]           retire_mask, eff_busy, set_mask;
    logic                      hazard, latch, issue;

    generate
        if (SLOT_W * NLANE < 1024) begin : g_unused
            logic unused_bits;
            assign unused_bits = ^bundle[1023:SLOT_W*NLANE];
        end
    endgenerate

    // Lowest valid lane keeps a contested destination; higher copies lose v.
    always_comb begin
        slots_in = bundle[SLOT_W*NLANE-1:0];
        for (int i = 0; i < NLANE; i++) begin
            v_in[i] = bundle[SLOT_W*i + V_BIT];
        end
        for (int i = 0; i < NLANE; i++) begin
            dup[i] = 1'b0;
            for (int j = 0; j < i; j++) begin
                if (v_in[i] && v_in[j] &&
                    rd_idx(bundle[SLOT_W*i +: SLOT_W]) == rd_idx(bundle[SLOT_W*j +: SLOT_W]))
                    dup[i] = 1'b1;
            end
            if (dup[i]) slots_in[SLOT_W*i + V_BIT] = 1'b0;
        end
    end

    // Retiring bits are treated as free this cycle so a dependent can issue
    // on the write-back cycle itself.
    always_comb begin
        hazard   = 1'b0;
        set_mask = '0;
        eff_busy = sb_busy & ~retire_mask;
        for (int i = 0; i < NLANE; i++) begin
            lane_v[i] = slots_q[SLOT_W*i + V_BIT];
            if (lane_v[i]) begin
                if (eff_busy[rs1_idx(slots_q[SLOT_W*i +: SLOT_W])] ||
                    eff_busy[rs2_idx(slots_q[SLOT_W*i +: SLOT_W])] ||
                    eff_busy[rd_idx(slots_q[SLOT_W*i +: SLOT_W])])
                    hazard = 1'b1;
                set_mask[rd_idx(slots_q[SLOT_W*i +: SLOT_W])] = 1'b1;
            end
        end
    end

    // Ready is withheld during flush so a presented bundle is never dropped.
    always_comb begin
        state_next   = state;
        bundle_ready = 1'b0;
        latch        = 1'b0;
        issue        = 1'b0;
        case (state)
            S_IDLE: begin
                bundle_ready = ~flush;
                if (bundle_valid && !flush) begin
                    latch      = 1'b1;
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    state_next = S_IDLE;
                end else if (!hazard) begin
                    issue      = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign issue_valid   = issue;
    assign issue_lane_en = issue ? lane_v : '0;
    assign issue_slots   = slots_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            slots_q      <= '0;
            err_waw      <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state   <= state_next;
            err_waw <= latch && (|dup);
            if (latch) slots_q <= slots_in;
            if (state == S_HOLD && hazard && stall_cycles != '1)
                stall_cycles <= stall_cycles + 1'b1;
        end
    end

    vliw_scoreboard #(
        .ALU_LAT (ALU_LAT)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .set_en      (issue),
        .set_mask    (set_mask),
        .sb_busy     (sb_busy),
        .retire_mask (retire_mask)
    );

endmodule

// File: tb/tb_vliw_issue_sched.sv
// Directed bench for vliw_issue_sched: expected issues go into a queue that
// a negedge monitor drains; scoreboard/counter state is checked inline.
module tb_vliw_issue_sched;

    localparam int NLANE = 26;

    typedef struct {
        logic [NLANE-1:0] lane_en;
        logic [31:0]      slot0;
        int               cyc;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                bundle_valid = 1'b0;
    logic                bundle_ready;
    logic [1023:0]       bundle = '0;
    logic                flush = 1'b0;
    logic                issue_valid;
    logic [NLANE-1:0]    issue_lane_en;
    logic [32*NLANE-1:0] issue_slots;
    logic [63:0]         sb_busy;
    logic [15:0]         stall_cycles;
    logic                err_waw;

    logic                s_bundle_valid = 1'b0;
    logic                s_bundle_ready;
    logic [1023:0]       s_bundle = '0;
    logic                s_flush = 1'b0;
    logic                s_issue_valid;
    logic [NLANE-1:0]    s_issue_lane_en;
    logic [32*NLANE-1:0] s_issue_slots;
    logic [63:0]         s_sb_busy;
    logic [3:0]          s_stall;
    logic                s_err_waw;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t expq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vliw_issue_sched dut (
        .clk(clk), .rst(rst), .bundle_valid(bundle_valid), .bundle_ready(bundle_ready),
        .bundle(bundle), .flush(flush), .issue_valid(issue_valid),
        .issue_lane_en(issue_lane_en), .issue_slots(issue_slots), .sb_busy(sb_busy),
        .stall_cycles(stall_cycles), .err_waw(err_waw)
    );

    vliw_issue_sched #(.NLANE(NLANE), .ALU_LAT(30), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .bundle_valid(s_bundle_valid), .bundle_ready(s_bundle_ready),
        .bundle(s_bundle), .flush(s_flush), .issue_valid(s_issue_valid),
        .issue_lane_en(s_issue_lane_en), .issue_slots(s_issue_slots), .sb_busy(s_sb_busy),
        .stall_cycles(s_stall), .err_waw(s_err_waw)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic tick_to(input int t);
        while (cyc < t) tick();
    endtask

    function automatic logic [31:0] mk_slot(input logic bank, input logic [4:0] rd,
                                            input logic [4:0] rs1, input logic [4:0] rs2);
        return {1'b1, bank, 6'h2A, rd, rs1, rs2, 9'h055};
    endfunction

    // Present a bundle once ready is seen; returns the accept cycle.
    task automatic send(input logic [1023:0] b, output int acc);
        int n;
        n = 0;
        while (!bundle_ready && n < 50) begin
            tick();
            n++;
        end
        if (!bundle_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: bundle_ready still %b after %0d cycles", bundle_ready, n);
        end
        bundle_valid = 1'b1;
        bundle       = b;
        acc          = cyc;
        tick();
        bundle_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [NLANE-1:0] le, input logic [31:0] s0, input int c);
        exp_t e;
        e.lane_en = le;
        e.slot0   = s0;
        e.cyc     = c;
        expq.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && issue_valid) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue @cyc %0d: lane_en %h, none expected", cyc, issue_lane_en);
            end else begin
                e = expq.pop_front();
                chk("issue_cycle", 64'(cyc), 64'(e.cyc));
                chk("issue_lane_en", 64'(issue_lane_en), 64'(e.lane_en));
                chk("issue_slot0", 64'(issue_slots[31:0]), 64'(e.slot0));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not finish, cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [1023:0] b;
        logic [31:0]   sa, sb2;
        int            a, acc, k;

        // Reset state
        ticks(3);
        chk("rst_bundle_ready", 64'(bundle_ready), 64'd1);
        chk("rst_issue_valid", 64'(issue_valid), 64'd0);
        chk("rst_lane_en", 64'(issue_lane_en), 64'd0);
        chk("rst_slots", 64'(issue_slots[63:0]), 64'd0);
        chk("rst_sb_busy", sb_busy, 64'd0);
        chk("rst_stall", 64'(stall_cycles), 64'd0);
        chk("rst_err_waw", 64'(err_waw), 64'd0);
        rst = 1'b0;
        ticks(2);

        // 1: g3 and f3 written, busy for three cycles
        b = '0;
        sa = mk_slot(1'b0, 5'd3, 5'd1, 5'd2);
        b[31:0]  = sa;
        b[63:32] = mk_slot(1'b1, 5'd3, 5'd1, 5'd2);
        send(b, a);
        push_exp(26'h3, sa, a + 1);
        tick();
        chk("t1_sb_busy_c2", sb_busy, 64'h0000_0008_0000_0008);
        tick();
        chk("t1_sb_busy_c3", sb_busy, 64'h0000_0008_0000_0008);
        tick();
        chk("t1_sb_busy_c4", sb_busy, 64'h0000_0008_0000_0008);
        tick();
        chk("t1_sb_busy_clear", sb_busy, 64'h0);
        ticks(2);

        // 2: RAW on g5, dependent issues on the retire cycle
        b = '0;
        sa = mk_slot(1'b0, 5'd5, 5'd1, 5'd2);
        b[31:0] = sa;
        send(b, a);
        push_exp(26'h1, sa, a + 1);
        b = '0;
        sb2 = mk_slot(1'b0, 5'd6, 5'd5, 5'd2);
        b[31:0] = sb2;
        send(b, acc);
        chk("t2_b_accept_cycle", 64'(acc), 64'(a + 2));
        push_exp(26'h1, sb2, a + 4);
        tick_to(a + 5);
        chk("t2_stall_cycles", 64'(stall_cycles), 64'd1);
        chk("t2_sb_g6", sb_busy, 64'h40);
        ticks(4);

        // 3: lanes 2 and 7 both write g9
        b = '0;
        sa = mk_slot(1'b0, 5'd9, 5'd1, 5'd2);
        b[95:64]   = sa;
        b[255:224] = mk_slot(1'b0, 5'd9, 5'd3, 5'd4);
        send(b, a);
        push_exp(26'h4, 32'h0, a + 1);
        chk("t3_err_waw_pulse", 64'(err_waw), 64'd1);
        chk("t3_lane7_v_dropped", 64'(issue_slots[7*32+31]), 64'd0);
        chk("t3_lane2_slot", 64'(issue_slots[95:64]), 64'(sa));
        tick();
        chk("t3_err_waw_end", 64'(err_waw), 64'd0);
        chk("t3_sb_only_g9", sb_busy, 64'h200);
        ticks(5);

        // 4: flush a stalled bundle
        b = '0;
        sa = mk_slot(1'b0, 5'd11, 5'd1, 5'd2);
        b[31:0] = sa;
        send(b, a);
        push_exp(26'h1, sa, a + 1);
        b = '0;
        b[31:0] = mk_slot(1'b0, 5'd16, 5'd11, 5'd2);
        send(b, acc);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("t4_ready_after_flush", 64'(bundle_ready), 64'd1);
        chk("t4_sb_g11_still", sb_busy, 64'h800);
        tick();
        chk("t4_sb_cleared", sb_busy, 64'h0);
        ticks(2);

        // 4b: flush beats an otherwise hazard-free issue
        b = '0;
        b[31:0] = mk_slot(1'b0, 5'd17, 5'd1, 5'd2);
        send(b, acc);
        flush = 1'b1;
        #1;
        chk("t4b_issue_blocked", 64'(issue_valid), 64'd0);
        tick();
        flush = 1'b0;
        tick();
        chk("t4b_sb_untouched", sb_busy, 64'h0);
        ticks(2);

        // 5: stall counter saturation (CNT_W=4, ALU_LAT=30 instance)
        k = cyc;
        s_bundle = '0;
        s_bundle[31:0] = mk_slot(1'b0, 5'd20, 5'd1, 5'd2);
        s_bundle_valid = 1'b1;
        chk("t5_sat_ready", 64'(s_bundle_ready), 64'd1);
        tick();
        s_bundle_valid = 1'b0;
        tick();
        s_bundle[31:0] = mk_slot(1'b0, 5'd21, 5'd20, 5'd2);
        s_bundle_valid = 1'b1;
        tick();
        s_bundle_valid = 1'b0;
        chk("t5_stall_start", 64'(s_stall), 64'd0);
        tick_to(k + 18);
        chk("t5_stall_at_max", 64'(s_stall), 64'hF);
        tick_to(k + 20);
        chk("t5_stall_no_wrap", 64'(s_stall), 64'hF);
        tick_to(k + 30);
        chk("t5_no_issue_before_retire", 64'(s_issue_valid), 64'd0);
        tick_to(k + 31);
        chk("t5_issue_on_retire", 64'(s_issue_valid), 64'd1);
        tick();
        chk("t5_stall_held", 64'(s_stall), 64'hF);
        ticks(2);

        // 6: reset with writes in flight
        b = '0;
        sa = mk_slot(1'b0, 5'd12, 5'd1, 5'd2);
        b[31:0]  = sa;
        b[63:32] = mk_slot(1'b0, 5'd13, 5'd1, 5'd2);
        b[95:64] = mk_slot(1'b0, 5'd14, 5'd1, 5'd2);
        send(b, a);
        push_exp(26'h7, sa, a + 1);
        tick();
        chk("t6_sb_before_rst", sb_busy, 64'h7000);
        rst = 1'b1;
        #1;
        chk("t6_sb_rst", sb_busy, 64'h0);
        chk("t6_issue_rst", 64'(issue_valid), 64'd0);
        chk("t6_stall_rst", 64'(stall_cycles), 64'd0);
        chk("t6_ready_rst", 64'(bundle_ready), 64'd1);
        tick();
        rst = 1'b0;
        tick();
        b = '0;
        sa = mk_slot(1'b0, 5'd15, 5'd12, 5'd13);
        b[31:0]  = sa;
        b[63:32] = mk_slot(1'b0, 5'd18, 5'd14, 5'd1);
        send(b, acc);
        push_exp(26'h3, sa, acc + 1);
        ticks(5);
        chk("t6_no_stall", 64'(stall_cycles), 64'd0);
        chk("pending_issues", 64'(expq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
